// File: rtl/spi_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SPI bridge slave port.
// Grants per CYC frame, muxes the granted master to the slave, and times out unacknowledged strobes.
module spi_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       m0_addr,
  input  logic              m0_we,
  input  logic              m0_stb,
  input  logic              m0_cyc,
  input  logic [DATA_W-1:0] m0_dout,
  output logic [DATA_W-1:0] m0_din,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [31:0]       m1_addr,
  input  logic              m1_we,
  input  logic              m1_stb,
  input  logic              m1_cyc,
  input  logic [DATA_W-1:0] m1_dout,
  output logic [DATA_W-1:0] m1_din,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [31:0]       s_addr,
  output logic              s_we,
  output logic              s_stb,
  output logic              s_cyc,
  output logic [DATA_W-1:0] s_dout,
  input  logic [DATA_W-1:0] s_din,
  input  logic              s_ack,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       prio, prio_nxt;   // 0: m0 preferred on a tie
  logic [7:0] wd_cnt, wd_nxt;
  logic       stb_sel, timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      wd_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      prio   <= prio_nxt;
      wd_cnt <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_nxt = prio ? GNT1 : GNT0;
        else if (m0_cyc)      state_nxt = GNT0;
        else if (m1_cyc)      state_nxt = GNT1;
      end
      GNT0: if (!m0_cyc) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b1;
      end
      GNT1: if (!m1_cyc) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt = {state == GNT1, state == GNT0};

  always_comb begin
    s_addr  = '0;
    s_we    = 1'b0;
    stb_sel = 1'b0;
    s_cyc   = 1'b0;
    s_dout  = '0;
    case (gnt)
      2'b01: begin
        s_addr = m0_addr; s_we = m0_we; stb_sel = m0_stb; s_cyc = m0_cyc; s_dout = m0_dout;
      end
      2'b10: begin
        s_addr = m1_addr; s_we = m1_we; stb_sel = m1_stb; s_cyc = m1_cyc; s_dout = m1_dout;
      end
      default: ;
    endcase
  end

  // Watchdog counts on the raw selected strobe; an ACK in the terminal cycle beats the timeout.
  assign timeout = stb_sel && !s_ack && (wd_cnt == WD_LAST);
  assign s_stb   = stb_sel && !timeout;

  always_comb begin
    if (!stb_sel || s_ack || timeout) wd_nxt = 8'd0;
    else                              wd_nxt = wd_cnt + 8'd1;
  end

  assign m0_ack = s_ack & gnt[0] & m0_stb;
  assign m1_ack = s_ack & gnt[1] & m1_stb;
  assign m0_err = timeout & gnt[0];
  assign m1_err = timeout & gnt[1];
  assign m0_din = gnt[0] ? s_din : '0;
  assign m1_din = gnt[1] ? s_din : '0;

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// Directed bench for spi_wb_arbiter: grant order, round-robin, mux, watchdog and async reset.
module tb_spi_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m1_addr, m0_dout, m1_dout, m0_din, m1_din;
  logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] s_addr, s_dout, s_din;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [1:0]  gnt;

  int total = 0;
  int fails = 0;

  spi_wb_arbiter #(.TIMEOUT(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_we(m0_we), .m0_stb(m0_stb), .m0_cyc(m0_cyc),
    .m0_dout(m0_dout), .m0_din(m0_din), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_we(m1_we), .m1_stb(m1_stb), .m1_cyc(m1_cyc),
    .m1_dout(m1_dout), .m1_din(m1_din), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
    .s_dout(s_dout), .s_din(s_din), .s_ack(s_ack), .gnt(gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0;
    m0_we = 0; m1_we = 0; m0_stb = 0; m1_stb = 0; m0_cyc = 0; m1_cyc = 0;
    s_din = '0; s_ack = 0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("rst_s_stb", 32'(s_stb), 32'h0);
    chk("rst_m0_ack", 32'(m0_ack), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // single master write, slave acks in its 3rd cycle
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h0; m0_dout = 32'h155;
    #1 chk("t1_pre_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_s_cyc", 32'(s_cyc), 32'h1);
    chk("t1_s_stb", 32'(s_stb), 32'h1);
    chk("t1_s_we", 32'(s_we), 32'h1);
    chk("t1_s_addr", s_addr, 32'h0);
    chk("t1_s_dout", s_dout, 32'h155);
    chk("t1_ack_early", 32'(m0_ack), 32'h0);
    tick(); tick();
    s_ack = 1; s_din = 32'hABCD;
    #1;
    chk("t1_m0_ack", 32'(m0_ack), 32'h1);
    chk("t1_m1_ack", 32'(m1_ack), 32'h0);
    chk("t1_m0_din", m0_din, 32'hABCD);
    chk("t1_m1_din", m1_din, 32'h0);
    tick();
    s_ack = 0; m0_stb = 0; m0_cyc = 0; m0_we = 0;
    #1 chk("t1_ack_once", 32'(m0_ack), 32'h0);
    tick();
    chk("t1_release", 32'(gnt), 32'h0);
    chk("t1_rel_s_cyc", 32'(s_cyc), 32'h0);

    // simultaneous request after reset: m0 first
    rst = 1; tick(); rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
    tick();
    chk("t2_gnt_m0", 32'(gnt), 32'h1);
    chk("t2_s_addr_m0", s_addr, 32'h100);
    s_ack = 1; s_din = 32'h77;
    #1;
    chk("t2_m0_ack", 32'(m0_ack), 32'h1);
    chk("t2_m1_ack_blocked", 32'(m1_ack), 32'h0);
    chk("t2_m1_din_blocked", m1_din, 32'h0);
    s_ack = 0;
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t2_idle_gap", 32'(gnt), 32'h0);
    tick();
    chk("t2_gnt_m1", 32'(gnt), 32'h2);
    chk("t2_s_addr_m1", s_addr, 32'h200);
    chk("t2_m0_err", 32'(m0_err), 32'h0);
    m1_cyc = 0; m1_stb = 0;
    tick();
    chk("t2_rel_m1", 32'(gnt), 32'h0);
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("t2_rotated_m0", 32'(gnt), 32'h1);

    // fairness: both keep requesting, holder drops and re-requests
    for (int i = 0; i < 4; i++) begin
      if (gnt == 2'b01) m0_cyc = 0; else m1_cyc = 0;
      tick();
      chk("fair_idle", 32'(gnt), 32'h0);
      m0_cyc = 1; m1_cyc = 1;
      tick();
      chk("fair_gnt", 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h1);
    end
    m0_cyc = 0; m1_cyc = 0;
    tick();
    chk("fair_end", 32'(gnt), 32'h0);

    // watchdog with TIMEOUT=4, m1 granted, no ack
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h300;
    tick();
    chk("wd_gnt", 32'(gnt), 32'h2);
    chk("wd_c1_stb", 32'(s_stb), 32'h1);
    chk("wd_c1_err", 32'(m1_err), 32'h0);
    tick(); tick();
    chk("wd_c3_err", 32'(m1_err), 32'h0);
    chk("wd_c3_stb", 32'(s_stb), 32'h1);
    tick();
    chk("wd_c4_err", 32'(m1_err), 32'h1);
    chk("wd_c4_stb", 32'(s_stb), 32'h0);
    chk("wd_c4_m0_err", 32'(m0_err), 32'h0);
    chk("wd_c4_ack", 32'(m1_ack), 32'h0);
    tick();
    chk("wd_c5_err", 32'(m1_err), 32'h0);
    chk("wd_c5_stb", 32'(s_stb), 32'h1);
    chk("wd_c5_gnt", 32'(gnt), 32'h2);
    tick(); tick(); tick();
    s_ack = 1;
    #1;
    chk("col_ack", 32'(m1_ack), 32'h1);
    chk("col_err", 32'(m1_err), 32'h0);
    chk("col_stb", 32'(s_stb), 32'h1);
    s_ack = 0;
    m1_cyc = 0; m1_stb = 0;
    tick();
    chk("wd_release", 32'(gnt), 32'h0);

    // async reset mid-read
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h40;
    tick();
    chk("ar_gnt", 32'(gnt), 32'h1);
    s_ack = 1;
    #1 chk("ar_pre_ack", 32'(m0_ack), 32'h1);
    rst = 1;
    #1;
    chk("ar_gnt0", 32'(gnt), 32'h0);
    chk("ar_s_cyc", 32'(s_cyc), 32'h0);
    chk("ar_s_stb", 32'(s_stb), 32'h0);
    chk("ar_m0_ack", 32'(m0_ack), 32'h0);
    s_ack = 0;
    tick();
    chk("ar_hold", 32'(gnt), 32'h0);
    rst = 0;
    #1 chk("ar_rel_nognt", 32'(gnt), 32'h0);
    tick();
    chk("ar_regrant", 32'(gnt), 32'h1);
    chk("ar_regrant_addr", s_addr, 32'h40);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/spi_wb_arbiter.md
# spi_wb_arbiter

Two-master Wishbone arbiter that shares the single Wishbone slave port of the SPI bridge between two requesters, e.g. the CPU and a DMA/boot sequencer. It grants the bus per Wishbone cycle (CYC-framed), rotates priority round-robin, and muxes address, data and control to the slave. A watchdog terminates strobes the slave never acknowledges.

## Interface
- TIMEOUT, 255: cycles of granted STB without ACK before error termination; legal range 1..255; 8-bit counter.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_addr / m1_addr  in  32  master address
- m0_we / m1_we  in  1  master write enable
- m0_stb / m1_stb  in  1  master strobe
- m0_cyc / m1_cyc  in  1  master bus cycle (the request)
- m0_dout / m1_dout  in  32  master-to-slave data
- m0_din / m1_din  out  32  slave-to-master data
- m0_ack / m1_ack  out  1  acknowledge to master
- m0_err / m1_err  out  1  timeout error to master
- s_addr  out  32  to slave wb_addr
- s_we  out  1  to slave wb_we
- s_stb  out  1  to slave wb_stb
- s_cyc  out  1  to slave wb_cyc
- s_dout  out  32  to slave wb_dout
- s_din  in  32  from slave wb_din
- s_ack  in  1  from slave wb_ack
- gnt  out  2  one-hot grant: bit0 = m0, bit1 = m1; 00 = idle

## Operation
- States: IDLE, GNT0, GNT1; gnt is the registered state decode.
- IDLE: if only m0_cyc -> GNT0; only m1_cyc -> GNT1; both -> master selected by priority pointer `prio`; neither -> stay.
- GNTk: stay while mk_cyc = 1; on mk_cyc = 0 -> IDLE; set prio to the other master.
- `prio` reset value: m0 preferred. It updates only on release, not on grant.
- Slave mux (combinational from gnt): s_addr/s_we/s_dout/s_stb/s_cyc = granted master's signals; all zero when gnt = 00.
- Return path: mk_ack = s_ack & gnt[k] & mk_stb; mk_din = s_din when gnt[k], else 0.
- Non-granted master sees ack = 0 and err = 0, and waits holding CYC/STB.
- Watchdog: `wd_cnt` 8 bits, cleared when not granted, when s_stb = 0, or when s_ack = 1. Otherwise it increments each cycle.
- When `wd_cnt` = TIMEOUT-1 and s_ack = 0: mk_err = 1 for one cycle, s_stb forced 0 that cycle, `wd_cnt` cleared. The master must deassert STB or retry.
- Grant is not revoked by timeout; only CYC deassertion releases.
- Simultaneous s_ack and timeout in the same cycle: ack wins, no err.

## Timing
- Reset values: gnt = 00, state IDLE, prio = m0, wd_cnt = 0. All outputs are 0 during and after reset until a grant.
- Grant latency: mk_cyc sampled high at edge N -> gnt[k] = 1 after edge N. The slave sees CYC/STB in cycle N+1.
- Release: mk_cyc low at edge M -> gnt = 00 after M. There is one mandatory IDLE cycle, so the earliest new grant is after edge M+1.
- Back-to-back accesses inside one CYC: no arbitration overhead; ACK passes through combinationally (zero added latency).
- Error pulse: exactly TIMEOUT cycles after STB is first seen by the slave without ACK (TIMEOUT=255 -> err in the 255th cycle).
- rst mid-transaction: immediate return to IDLE/outputs 0 (asynchronous). An ACK pending in the slave is discarded.
- Masters must keep CYC high for the full transaction; a CYC glitch releases the bus.

## Test plan
- Single master: m0 asserts cyc+stb, write addr 0x0, data 0x155, slave acks after 3 cycles -> gnt = 01 one cycle after request; s_addr = 0x0; s_dout = 0x155; m0_ack pulses once; m1_ack stays 0.
- Simultaneous request after reset: m0_cyc and m1_cyc rise in the same cycle -> m0 granted first. After m0 drops cyc: 1 IDLE cycle, then gnt = 10. Next simultaneous request -> m0 granted (prio rotated back).
- Fairness: m0 requests continuously and m1 holds its request -> grants alternate 01, 00, 10, 00, 01 …; m1 is never starved.
- Timeout: TIMEOUT = 4, m1 granted, slave never acks -> m1_err = 1 in the 4th strobe cycle with s_stb = 0 that cycle. gnt stays 10 until m1 drops cyc.
- Ack/timeout collision: TIMEOUT = 4, s_ack arrives in the 4th cycle -> m1_ack = 1, m1_err = 0.
- Async reset: assert rst mid-read while gnt = 01 -> gnt, s_cyc, s_stb and m0_ack are 0 immediately, before the next clock edge. After release, m0 still holding cyc is re-granted one cycle later.
